pipeline_elastic_stage: RTL and testbench

Parametrised elastic pipeline register for use between any two stages of the SimpleCPU pipeline (fetch→decode, decode→exec, exec→mem). It replaces the fixed stall/flush register with a valid/ready handshake and a DEPTH-entry in-order buffer. It adds selective kill of in-flight entries younger than a mispredicted branch, using the active-list index as an age tag. The payload is an opaque PAYLOAD_WIDTH bus; the instantiating stage packs its control and data fields into it.

---
 rtl/pipeline_elastic_stage.sv | 160 ++++++++++++++++
 tb/tb_pipeline_elastic_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_elastic_stage.sv
// ---------------------------------------------------------------------------
// pipeline_elastic_stage
//
// Elastic pipeline register that sits between two SimpleCPU pipeline stages.
// It holds up to DEPTH entries in order in a circular buffer. Each entry is
// an opaque payload plus an active-list tag. Upstream and downstream use a
// valid/ready handshake. The stage supports a full flush and a selective
// kill. The kill removes every entry that is younger than a mispredicted
// branch, with age measured relative to the oldest active-list index.
//
// Ports:
//   clk, rst_n            clock (rising edge) and async active-low reset
//   in_valid / in_ready   upstream handshake
//   in_payload, in_tag    upstream entry contents
//   out_valid / out_ready downstream handshake
//   out_payload, out_tag  head entry contents, zero while empty
//   flush                 discard everything, including this cycle's push
//   kill_valid, kill_tag  drop entries strictly younger than kill_tag
//   kill_head             oldest active-list index, the age reference
//   occupancy             number of valid entries
// ---------------------------------------------------------------------------
module pipeline_elastic_stage #(
    parameter int PAYLOAD_WIDTH = 160,
    parameter int DEPTH         = 2,
    parameter int TAG_WIDTH     = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PAYLOAD_WIDTH-1:0] in_payload,
    input  logic [TAG_WIDTH-1:0]     in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PAYLOAD_WIDTH-1:0] out_payload,
    output logic [TAG_WIDTH-1:0]     out_tag,
    input  logic                     flush,
    input  logic                     kill_valid,
    input  logic [TAG_WIDTH-1:0]     kill_tag,
    input  logic [TAG_WIDTH-1:0]     kill_head,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]         head_q, head_d;
    logic [PTR_W-1:0]         tail_q, tail_d;
    logic [CNT_W-1:0]         count_q, count_d;

    logic [PAYLOAD_WIDTH-1:0] payload_mem_q [DEPTH];
    logic [TAG_WIDTH-1:0]     tag_mem_q     [DEPTH];

    logic                     wr_en;
    logic [PTR_W-1:0]         wr_addr;
    logic                     push;
    logic                     pop;
    logic [TAG_WIDTH-1:0]     kill_age;
    logic [TAG_WIDTH-1:0]     in_age;
    logic                     in_survives;
    logic [CNT_W-1:0]         surv_cnt;
    logic                     surv_alive;
    logic [PTR_W-1:0]         surv_idx;
    logic [TAG_WIDTH-1:0]     surv_age;

    // Handshake signals depend only on registered state. This keeps out_ready
    // from reaching in_ready through a combinational path.
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_payload = out_valid ? payload_mem_q[head_q] : '0;
    assign out_tag     = out_valid ? tag_mem_q[head_q]     : '0;
    assign occupancy   = count_q;

    // Ages are modulo 2^TAG_WIDTH distances from the oldest active-list slot.
    // This keeps the comparison correct when the tags wrap around.
    assign kill_age    = kill_tag - kill_head;
    assign in_age      = in_tag - kill_head;
    assign in_survives = (in_age <= kill_age);

    // Count the entries that survive a kill, walking from the head. The
    // entry popped this cycle has already left, so the walk skips it. The
    // walk stops at the first killed entry. Entries are in program order,
    // so everything after that entry is younger and is killed as well.
    always_comb begin
        surv_cnt   = '0;
        surv_alive = 1'b1;
        surv_idx   = '0;
        surv_age   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            surv_idx = head_q + PTR_W'(i);
            surv_age = tag_mem_q[surv_idx] - kill_head;
            if ((CNT_W'(i) < count_q) && !(pop && (i == 0))) begin
                if (surv_alive && (surv_age <= kill_age)) begin
                    surv_cnt = surv_cnt + CNT_W'(1);
                end else begin
                    surv_alive = 1'b0;
                end
            end
        end
    end

    // Next-state pointer and count logic. Priority is flush, then kill, then
    // plain push/pop. A pop in any of these cycles still completes
    // downstream, so the head always advances past it.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_addr = tail_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (kill_valid) begin
            head_d  = head_q + PTR_W'(pop);
            tail_d  = head_d + surv_cnt[PTR_W-1:0];
            count_d = surv_cnt;
            if (push && in_survives) begin
                wr_en   = 1'b1;
                wr_addr = tail_d;
                tail_d  = tail_d + PTR_W'(1);
                count_d = surv_cnt + CNT_W'(1);
            end
        end else begin
            head_d  = head_q + PTR_W'(pop);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            if (push) begin
                wr_en   = 1'b1;
                wr_addr = tail_q;
                tail_d  = tail_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage has no reset. Flush and kill only move the pointers, and the
    // empty-case output mux hides any stale contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            payload_mem_q[wr_addr] <= in_payload;
            tag_mem_q[wr_addr]     <= in_tag;
        end
    end

endmodule

// File: tb/tb_pipeline_elastic_stage.sv
// ---------------------------------------------------------------------------
// tb_pipeline_elastic_stage
//
// Directed self-checking bench for pipeline_elastic_stage with DEPTH=2.
// Each scenario task drives its own vectors and checks the expected values
// inline. The tests cover pass-through, back-pressure, kill, tag wrap, a
// concurrent push/pop/kill, flush, and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_pipeline_elastic_stage;

    localparam int PW = 160;
    localparam int TW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_payload;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_payload;
    logic [TW-1:0] out_tag;
    logic          flush;
    logic          kill_valid;
    logic [TW-1:0] kill_tag;
    logic [TW-1:0] kill_head;
    logic [1:0]    occupancy;

    int tests_run  = 0;
    int tests_fail = 0;

    pipeline_elastic_stage #(
        .PAYLOAD_WIDTH(PW),
        .DEPTH(2),
        .TAG_WIDTH(TW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_payload (in_payload),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_payload(out_payload),
        .out_tag    (out_tag),
        .flush      (flush),
        .kill_valid (kill_valid),
        .kill_tag   (kill_tag),
        .kill_head  (kill_head),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid   = 1'b0;
        in_payload = '0;
        in_tag     = '0;
        out_ready  = 1'b0;
        flush      = 1'b0;
        kill_valid = 1'b0;
        kill_tag   = '0;
        kill_head  = '0;
    endtask

    // Push one entry while downstream stalls.
    task automatic push_stalled(input logic [TW-1:0] tag, input logic [PW-1:0] pay);
        in_valid   = 1'b1;
        in_tag     = tag;
        in_payload = pay;
        out_ready  = 1'b0;
        step();
        in_valid   = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        tests_run++; if (out_valid !== 1'b0) begin tests_fail++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", out_valid); end
        tests_run++; if (out_payload !== '0) begin tests_fail++; $display("[TB] FAIL reset_out_payload: got %0h expected 0", out_payload); end
        tests_run++; if (out_tag !== '0) begin tests_fail++; $display("[TB] FAIL reset_out_tag: got %0h expected 0", out_tag); end
        tests_run++; if (in_ready !== 1'b1) begin tests_fail++; $display("[TB] FAIL reset_in_ready: got %0b expected 1", in_ready); end
        tests_run++; if (occupancy !== 2'd0) begin tests_fail++; $display("[TB] FAIL reset_occupancy: got %0d expected 0", occupancy); end
        #2 rst_n = 1'b1;
    endtask

    task automatic test_pass_through();
        logic [PW-1:0] exp_pay [3];
        exp_pay[0] = 160'h1;
        exp_pay[1] = 160'h2;
        exp_pay[2] = 160'h3;
        idle_inputs();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid   = 1'b1;
            in_payload = exp_pay[i];
            in_tag     = TW'(i);
            step();
            tests_run++; if (out_payload !== exp_pay[i] || out_valid !== 1'b1) begin tests_fail++; $display("[TB] FAIL pass_payload%0d: got %0h/v%0b expected %0h/v1", i, out_payload, out_valid, exp_pay[i]); end
            tests_run++; if (occupancy !== 2'd1) begin tests_fail++; $display("[TB] FAIL pass_occ%0d: got %0d expected 1", i, occupancy); end
        end
        in_valid = 1'b0;
        step();
        tests_run++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin tests_fail++; $display("[TB] FAIL pass_drain: got occ %0d v%0b expected occ 0 v0", occupancy, out_valid); end
    endtask

    task automatic test_backpressure();
        idle_inputs();
        push_stalled(3'd0, 160'h10);
        tests_run++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin tests_fail++; $display("[TB] FAIL bp_first: got occ %0d rdy %0b expected occ 1 rdy 1", occupancy, in_ready); end
        push_stalled(3'd1, 160'h11);
        tests_run++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin tests_fail++; $display("[TB] FAIL bp_full: got occ %0d rdy %0b expected occ 2 rdy 0", occupancy, in_ready); end
        // Tag 2 is offered while full and must stay upstream.
        in_valid = 1'b1; in_tag = 3'd2; in_payload = 160'h12;
        step();
        tests_run++; if (occupancy !== 2'd2 || out_tag !== 3'd0) begin tests_fail++; $display("[TB] FAIL bp_hold: got occ %0d tag %0d expected occ 2 tag 0", occupancy, out_tag); end
        out_ready = 1'b1;
        step();
        tests_run++; if (occupancy !== 2'd1 || out_tag !== 3'd1 || in_ready !== 1'b1) begin tests_fail++; $display("[TB] FAIL bp_pop0: got occ %0d tag %0d rdy %0b expected occ 1 tag 1 rdy 1", occupancy, out_tag, in_ready); end
        step();
        tests_run++; if (occupancy !== 2'd1 || out_tag !== 3'd2 || out_payload !== 160'h12) begin tests_fail++; $display("[TB] FAIL bp_pop1: got occ %0d tag %0d pay %0h expected occ 1 tag 2 pay 12", occupancy, out_tag, out_payload); end
        in_valid = 1'b0;
        step();
        tests_run++; if (occupancy !== 2'd0) begin tests_fail++; $display("[TB] FAIL bp_drain: got %0d expected 0", occupancy); end
    endtask

    task automatic test_kill();
        idle_inputs();
        push_stalled(3'd5, 160'h55);
        push_stalled(3'd6, 160'h66);
        kill_valid = 1'b1; kill_head = 3'd4; kill_tag = 3'd5;
        step();
        tests_run++; if (occupancy !== 2'd1 || out_tag !== 3'd5 || out_payload !== 160'h55) begin tests_fail++; $display("[TB] FAIL kill_younger: got occ %0d tag %0d expected occ 1 tag 5", occupancy, out_tag); end
        tests_run++; if (in_ready !== 1'b1) begin tests_fail++; $display("[TB] FAIL kill_ready: got %0b expected 1", in_ready); end
        kill_tag = 3'd4;
        step();
        tests_run++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_tag !== 3'd0) begin tests_fail++; $display("[TB] FAIL kill_all: got occ %0d v%0b tag %0d expected occ 0 v0 tag 0", occupancy, out_valid, out_tag); end
        kill_valid = 1'b0;
    endtask

    task automatic test_wrap();
        idle_inputs();
        push_stalled(3'd7, 160'h77);
        push_stalled(3'd0, 160'h80);
        kill_valid = 1'b1; kill_head = 3'd6; kill_tag = 3'd7;
        step();
        kill_valid = 1'b0;
        tests_run++; if (occupancy !== 2'd1 || out_tag !== 3'd7) begin tests_fail++; $display("[TB] FAIL wrap_kill: got occ %0d tag %0d expected occ 1 tag 7", occupancy, out_tag); end
        out_ready = 1'b1;
        step();
        tests_run++; if (occupancy !== 2'd0) begin tests_fail++; $display("[TB] FAIL wrap_drain: got %0d expected 0", occupancy); end
    endtask

    task automatic test_same_cycle();
        idle_inputs();
        push_stalled(3'd1, 160'h101);
        // Push tag 3, pop tag 1, kill younger than tag 2 in one cycle.
        in_valid = 1'b1; in_tag = 3'd3; in_payload = 160'h303;
        out_ready = 1'b1;
        kill_valid = 1'b1; kill_head = 3'd1; kill_tag = 3'd2;
        #1;
        tests_run++; if (out_valid !== 1'b1 || out_tag !== 3'd1) begin tests_fail++; $display("[TB] FAIL same_pop_offer: got v%0b tag %0d expected v1 tag 1", out_valid, out_tag); end
        step();
        tests_run++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin tests_fail++; $display("[TB] FAIL same_drop: got occ %0d v%0b expected occ 0 v0", occupancy, out_valid); end
        // A push that is no younger than kill_tag survives the kill.
        idle_inputs();
        push_stalled(3'd1, 160'h111);
        in_valid = 1'b1; in_tag = 3'd2; in_payload = 160'h222;
        kill_valid = 1'b1; kill_head = 3'd1; kill_tag = 3'd2;
        step();
        idle_inputs();
        tests_run++; if (occupancy !== 2'd2 || out_tag !== 3'd1 || in_ready !== 1'b0) begin tests_fail++; $display("[TB] FAIL same_survive: got occ %0d tag %0d rdy %0b expected occ 2 tag 1 rdy 0", occupancy, out_tag, in_ready); end
    endtask

    task automatic test_flush();
        // Buffer is full from the previous scenario.
        idle_inputs();
        flush = 1'b1; in_valid = 1'b1; in_tag = 3'd4; in_payload = 160'h444;
        step();
        tests_run++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_payload !== '0 || in_ready !== 1'b1) begin tests_fail++; $display("[TB] FAIL flush_full: got occ %0d v%0b pay %0h rdy %0b expected occ 0 v0 pay 0 rdy 1", occupancy, out_valid, out_payload, in_ready); end
        // Flush also drops a push into a partly filled buffer.
        idle_inputs();
        push_stalled(3'd5, 160'h555);
        flush = 1'b1; in_valid = 1'b1; in_tag = 3'd6; in_payload = 160'h666;
        step();
        idle_inputs();
        tests_run++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin tests_fail++; $display("[TB] FAIL flush_push: got occ %0d v%0b expected occ 0 v0", occupancy, out_valid); end
        step();
        tests_run++; if (occupancy !== 2'd0) begin tests_fail++; $display("[TB] FAIL flush_stays_empty: got %0d expected 0", occupancy); end
    endtask

    task automatic test_async_reset();
        idle_inputs();
        push_stalled(3'd2, 160'h202);
        push_stalled(3'd3, 160'h303);
        tests_run++; if (occupancy !== 2'd2) begin tests_fail++; $display("[TB] FAIL arst_prefill: got %0d expected 2", occupancy); end
        #2 rst_n = 1'b0;
        #1;
        tests_run++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_payload !== '0 || out_tag !== '0 || in_ready !== 1'b1) begin tests_fail++; $display("[TB] FAIL arst_immediate: got occ %0d v%0b pay %0h tag %0d rdy %0b expected zeros rdy 1", occupancy, out_valid, out_payload, out_tag, in_ready); end
        #2 rst_n = 1'b1;
        step();
        tests_run++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin tests_fail++; $display("[TB] FAIL arst_after: got occ %0d v%0b expected occ 0 v0", occupancy, out_valid); end
        // The stage works normally after the reset.
        in_valid = 1'b1; in_tag = 3'd4; in_payload = 160'hABC; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        tests_run++; if (out_payload !== 160'hABC || out_tag !== 3'd4) begin tests_fail++; $display("[TB] FAIL arst_resume: got pay %0h tag %0d expected abc tag 4", out_payload, out_tag); end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_backpressure();
        test_kill();
        test_wrap();
        test_same_cycle();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

endmodule
